alu_writeback: RTL

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback_pkg.sv | 30 +++
 rtl/alu_writeback_if.sv | 33 +++
 rtl/alu_writeback_wb_fifo.sv | 89 ++++++++
 rtl/alu_writeback.sv | 83 ++++++++
 4 files changed

// File: rtl/alu_writeback_pkg.sv
// Shared core types for the ALU and its writeback stage: opcodes, flag bundle
// and default sizing constants.
package alu_writeback_pkg;

  localparam int WB_DEPTH_DEF = 2;
  localparam int WB_NREGS_DEF = 8;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_SHR = 4'd6,
    ALU_PASS = 4'd7
  } ALUOp;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } Flags;

  function automatic Flags flags_none();
    return '0;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-result input handshake and register-file write port of the writeback stage.
interface alu_writeback_if import alu_writeback_pkg::*; #(
  parameter int NREGS = WB_NREGS_DEF
) ();
  localparam int RW = $clog2(NREGS);

  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_result;
  Flags          in_flags;
  logic [RW-1:0] in_rd;
  logic          in_wr_en;
  logic          in_flags_en;

  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [15:0]   rf_wdata;
  logic          rf_ready;

  Flags             flags_q;
  logic [NREGS-1:0] pending;

  modport master (
    output in_valid, in_result, in_flags, in_rd, in_wr_en, in_flags_en, rf_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata, flags_q, pending
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_rd, in_wr_en, in_flags_en, rf_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata, flags_q, pending
  );

endinterface

// File: rtl/alu_writeback_wb_fifo.sv
// In-order buffer of ALU results awaiting retirement; exposes the head entry
// and per-slot destination info so the parent can build the pending mask.
module wb_fifo import alu_writeback_pkg::*; #(
  parameter int DEPTH = WB_DEPTH_DEF,
  parameter int NREGS = WB_NREGS_DEF,
  localparam int RW = $clog2(NREGS),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [15:0]               i_result,
  input  Flags                      i_flags,
  input  logic [RW-1:0]             i_rd,
  input  logic                      i_wr_en,
  input  logic                      i_flags_en,
  input  logic                      i_pop,
  output logic [CW-1:0]             o_count,
  output logic [15:0]               o_head_result,
  output Flags                      o_head_flags,
  output logic [RW-1:0]             o_head_rd,
  output logic                      o_head_wr_en,
  output logic                      o_head_flags_en,
  output logic [DEPTH-1:0]          o_slot_wr,
  output logic [DEPTH-1:0][RW-1:0]  o_slot_rd
);

  logic [15:0]   r_result [DEPTH];
  Flags          r_flags  [DEPTH];
  logic [RW-1:0] r_rd     [DEPTH];
  logic [DEPTH-1:0] r_wr_en;
  logic [DEPTH-1:0] r_flags_en;
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Payload needs no reset; r_vld alone says which slots hold live entries.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_result[r_wptr]   <= i_result;
      r_flags[r_wptr]    <= i_flags;
      r_rd[r_wptr]       <= i_rd;
      r_wr_en[r_wptr]    <= i_wr_en;
      r_flags_en[r_wptr] <= i_flags_en;
    end
  end

  // Push and pop never target the same slot: wptr == rptr only when empty or full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (i_push) begin
        r_wptr        <= r_wptr + PW'(1);
        r_vld[r_wptr] <= 1'b1;
      end
      if (i_pop) begin
        r_rptr        <= r_rptr + PW'(1);
        r_vld[r_rptr] <= 1'b0;
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count         = r_count;
  assign o_head_result   = r_result[r_rptr];
  assign o_head_flags    = r_flags[r_rptr];
  assign o_head_rd       = r_rd[r_rptr];
  assign o_head_wr_en    = r_wr_en[r_rptr];
  assign o_head_flags_en = r_flags_en[r_rptr];
  assign o_slot_wr       = r_vld & r_wr_en;

  always_comb begin
    o_slot_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_slot_rd[i] = r_rd[i];
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers results, drives register-file writes in order,
// owns the architectural flags and the pending-destination scoreboard.
module alu_writeback import alu_writeback_pkg::*; #(
  parameter int DEPTH = WB_DEPTH_DEF,
  parameter int NREGS = WB_NREGS_DEF
) (
  input logic            clk,
  input logic            rst,
  alu_writeback_if.slave wb
);

  localparam int RW = $clog2(NREGS);
  localparam int CW = $clog2(DEPTH + 1);

  logic                     w_push;
  logic                     w_pop;
  logic                     w_nonempty;
  logic [CW-1:0]            w_count;
  logic [15:0]              w_head_result;
  Flags                     w_head_flags;
  logic [RW-1:0]            w_head_rd;
  logic                     w_head_wr_en;
  logic                     w_head_flags_en;
  logic [DEPTH-1:0]         w_slot_wr;
  logic [DEPTH-1:0][RW-1:0] w_slot_rd;
  logic [NREGS-1:0]         w_pending;
  Flags                     r_flags;

  // in_ready depends only on the registered count, so no input reaches it.
  assign wb.in_ready = (w_count < CW'(DEPTH));
  assign w_nonempty  = (w_count != '0);
  assign w_push      = wb.in_valid && wb.in_ready;
  assign w_pop       = w_nonempty && (!w_head_wr_en || wb.rf_ready);

  wb_fifo #(
    .DEPTH (DEPTH),
    .NREGS (NREGS)
  ) u_fifo (
    .clk             (clk),
    .rst             (rst),
    .i_push          (w_push),
    .i_result        (wb.in_result),
    .i_flags         (wb.in_flags),
    .i_rd            (wb.in_rd),
    .i_wr_en         (wb.in_wr_en),
    .i_flags_en      (wb.in_flags_en),
    .i_pop           (w_pop),
    .o_count         (w_count),
    .o_head_result   (w_head_result),
    .o_head_flags    (w_head_flags),
    .o_head_rd       (w_head_rd),
    .o_head_wr_en    (w_head_wr_en),
    .o_head_flags_en (w_head_flags_en),
    .o_slot_wr       (w_slot_wr),
    .o_slot_rd       (w_slot_rd)
  );

  assign wb.rf_we    = w_nonempty && w_head_wr_en;
  assign wb.rf_waddr = w_head_rd;
  assign wb.rf_wdata = w_head_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= flags_none();
    end else if (w_pop && w_head_flags_en) begin
      r_flags <= w_head_flags;
    end
  end

  assign wb.flags_q = r_flags;

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_slot_wr[i]) begin
        w_pending[w_slot_rd[i]] = 1'b1;
      end
    end
  end

  assign wb.pending = w_pending;

endmodule
